// File: rtl/pma_region_checker.sv
`default_nettype none
// ============================================================================
// Module   : pma_region_checker
// Purpose  : Runtime-programmable PMA rule table with NrPorts registered
//            lookup channels and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pma_region_checker #(
    parameter int unsigned NrRules   = 16,
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [IdxWidth-1:0]          cfg_idx_i,
    input  logic [AddrWidth-1:0]         cfg_base_i,
    input  logic [AddrWidth-1:0]         cfg_len_i,
    input  logic [2:0]                   cfg_attr_i,
    input  logic                         cfg_en_i,
    input  logic                         cfg_lock_i,
    output logic                         cfg_locked_o,
    input  logic [NrPorts-1:0]           req_valid_i,
    output logic [NrPorts-1:0]           req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0] req_addr_i,
    input  logic [NrPorts*IdWidth-1:0]   req_id_i,
    output logic [NrPorts-1:0]           rsp_valid_o,
    input  logic [NrPorts-1:0]           rsp_ready_i,
    output logic [NrPorts*IdWidth-1:0]   rsp_id_o,
    output logic [NrPorts*3-1:0]         rsp_attr_o,
    output logic [NrPorts-1:0]           rsp_hit_o,
    output logic [NrPorts-1:0]           rsp_multi_o,
    output logic [31:0]                  miss_cnt_o
);

    logic [AddrWidth-1:0] r_ruleBase [NrRules];
    logic [AddrWidth-1:0] r_ruleLen  [NrRules];
    logic [2:0]           r_ruleAttr [NrRules];
    logic [NrRules-1:0]   r_ruleEn;
    logic                 r_locked;

    logic [NrPorts-1:0]   r_rspValid;
    logic [NrPorts-1:0]   r_rspHit;
    logic [NrPorts-1:0]   r_rspMulti;
    logic [IdWidth-1:0]   r_rspId   [NrPorts];
    logic [2:0]           r_rspAttr [NrPorts];
    logic [31:0]          r_missCnt;

    logic                 w_anyExec;
    logic [2:0]           w_lkAttr [NrPorts];
    logic [NrPorts-1:0]   w_lkHit;
    logic [NrPorts-1:0]   w_lkMulti;
    logic [NrPorts-1:0]   w_accept;
    logic [2:0]           w_missInc;
    logic [32:0]          w_missSum;

    // Out-of-range indices never equal any k, so they are dropped naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NrRules; k++) begin
                r_ruleBase[k] <= '0;
                r_ruleLen[k]  <= '0;
                r_ruleAttr[k] <= '0;
            end
            r_ruleEn <= '0;
            r_locked <= 1'b0;
        end else begin
            if (cfg_we_i && !r_locked) begin
                for (int k = 0; k < NrRules; k++) begin
                    if (cfg_idx_i == IdxWidth'(k)) begin
                        r_ruleBase[k] <= cfg_base_i;
                        r_ruleLen[k]  <= cfg_len_i;
                        r_ruleAttr[k] <= cfg_attr_i;
                        r_ruleEn[k]   <= cfg_en_i;
                    end
                end
            end
            if (cfg_lock_i) begin
                r_locked <= 1'b1;
            end
        end
    end

    always_comb begin
        w_anyExec = 1'b0;
        for (int k = 0; k < NrRules; k++) begin
            w_anyExec = w_anyExec | (r_ruleEn[k] & r_ruleAttr[k][1]);
        end
    end

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        logic [AddrWidth-1:0] w_addr;
        logic [NrRules-1:0]   w_match;
        logic [2:0]           w_attrOr;

        assign w_addr = req_addr_i[p*AddrWidth +: AddrWidth];

        // Region end is formed one bit wider so regions touching the top of
        // the address space do not wrap.
        always_comb begin
            w_match  = '0;
            w_attrOr = '0;
            for (int k = 0; k < NrRules; k++) begin
                if (r_ruleEn[k] && (w_addr >= r_ruleBase[k]) &&
                    ({1'b0, w_addr} < ({1'b0, r_ruleBase[k]} + {1'b0, r_ruleLen[k]}))) begin
                    w_match[k] = 1'b1;
                    w_attrOr   = w_attrOr | r_ruleAttr[k];
                end
            end
        end

        assign w_lkAttr[p]  = {w_attrOr[2], w_attrOr[1] | ~w_anyExec, w_attrOr[0]};
        assign w_lkHit[p]   = |w_match;
        assign w_lkMulti[p] = |(w_match & (w_match - NrRules'(1)));

        assign rsp_id_o[p*IdWidth +: IdWidth] = r_rspId[p];
        assign rsp_attr_o[p*3 +: 3]           = r_rspAttr[p];
    end

    assign req_ready_o = rst_i ? '0 : (~r_rspValid | rsp_ready_i);
    assign w_accept    = req_valid_i & req_ready_o;

    always_comb begin
        w_missInc = '0;
        for (int p = 0; p < NrPorts; p++) begin
            if (r_rspValid[p] && rsp_ready_i[p] && !r_rspHit[p]) begin
                w_missInc = w_missInc + 3'd1;
            end
        end
    end

    assign w_missSum = {1'b0, r_missCnt} + {30'd0, w_missInc};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rspValid <= '0;
            r_rspHit   <= '0;
            r_rspMulti <= '0;
            for (int p = 0; p < NrPorts; p++) begin
                r_rspId[p]   <= '0;
                r_rspAttr[p] <= '0;
            end
            r_missCnt <= '0;
        end else begin
            for (int p = 0; p < NrPorts; p++) begin
                if (w_accept[p]) begin
                    r_rspValid[p] <= 1'b1;
                    r_rspId[p]    <= req_id_i[p*IdWidth +: IdWidth];
                    r_rspAttr[p]  <= w_lkAttr[p];
                    r_rspHit[p]   <= w_lkHit[p];
                    r_rspMulti[p] <= w_lkMulti[p];
                end else if (rsp_ready_i[p]) begin
                    r_rspValid[p] <= 1'b0;
                end
            end
            r_missCnt <= w_missSum[32] ? 32'hFFFF_FFFF : w_missSum[31:0];
        end
    end

    assign cfg_locked_o = r_locked;
    assign rsp_valid_o  = r_rspValid;
    assign rsp_hit_o    = r_rspHit;
    assign rsp_multi_o  = r_rspMulti;
    assign miss_cnt_o   = r_missCnt;

endmodule
`default_nettype wire

// File: tb/tb_pma_region_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pma_region_checker
// Purpose  : Directed vectors, corner sequences and random traffic against a
//            rule-level reference model of pma_region_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pma_region_checker;

    localparam int NR = 16;
    localparam int NP = 2;
    localparam int AW = 64;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfgWe;
    logic [3:0]      cfgIdx;
    logic [AW-1:0]   cfgBase;
    logic [AW-1:0]   cfgLen;
    logic [2:0]      cfgAttr;
    logic            cfgEn;
    logic            cfgLock;
    logic            cfgLocked;
    logic [NP-1:0]   reqValid;
    logic [NP-1:0]   reqReady;
    logic [NP*AW-1:0] reqAddr;
    logic [NP*IW-1:0] reqId;
    logic [NP-1:0]   rspValid;
    logic [NP-1:0]   rspReady;
    logic [NP*IW-1:0] rspId;
    logic [NP*3-1:0] rspAttr;
    logic [NP-1:0]   rspHit;
    logic [NP-1:0]   rspMulti;
    logic [31:0]     missCnt;

    pma_region_checker #(
        .NrRules(NR), .NrPorts(NP), .AddrWidth(AW), .IdWidth(IW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_we_i(cfgWe), .cfg_idx_i(cfgIdx), .cfg_base_i(cfgBase),
        .cfg_len_i(cfgLen), .cfg_attr_i(cfgAttr), .cfg_en_i(cfgEn),
        .cfg_lock_i(cfgLock), .cfg_locked_o(cfgLocked),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_addr_i(reqAddr), .req_id_i(reqId),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
        .rsp_id_o(rspId), .rsp_attr_o(rspAttr),
        .rsp_hit_o(rspHit), .rsp_multi_o(rspMulti),
        .miss_cnt_o(missCnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mBase [NR];
    logic [63:0] mLen  [NR];
    logic [2:0]  mAttr [NR];
    bit          mEn   [NR];
    bit          mLocked;
    bit          mValid [NP];
    logic [3:0]  mId    [NP];
    logic [2:0]  mRAttr [NP];
    bit          mHit   [NP];
    bit          mMulti [NP];
    logic [31:0] mMiss;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  id;
        logic [2:0]  attr;
        bit          hit;
        bit          multi;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Rule semantics: region is [base, base+len); offset within region < len.
    task automatic lookup(input logic [63:0] a, output logic [2:0] attr,
                          output bit hit, output bit multi);
        int n = 0;
        bit anyX = 0;
        attr = 3'b000;
        for (int k = 0; k < NR; k++) begin
            if (mEn[k] && mAttr[k][1]) anyX = 1;
            if (mEn[k] && a >= mBase[k] && (a - mBase[k]) < mLen[k]) begin
                n++;
                attr = attr | mAttr[k];
            end
        end
        if (!anyX) attr[1] = 1'b1;
        hit   = (n > 0);
        multi = (n >= 2);
    endtask

    task automatic cycle();
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                mBase[k] = '0; mLen[k] = '0; mAttr[k] = '0; mEn[k] = 0;
            end
            mLocked = 0;
            mMiss = '0;
            for (int p = 0; p < NP; p++) begin
                mValid[p] = 0; mId[p] = '0; mRAttr[p] = '0; mHit[p] = 0; mMulti[p] = 0;
            end
        end else begin
            longint unsigned sum = mMiss;
            for (int p = 0; p < NP; p++) begin
                if (mValid[p] && rspReady[p] && !mHit[p]) sum++;
                if (reqValid[p] && (!mValid[p] || rspReady[p])) begin
                    mValid[p] = 1;
                    mId[p] = reqId[p*IW +: IW];
                    lookup(reqAddr[p*AW +: AW], mRAttr[p], mHit[p], mMulti[p]);
                end else if (rspReady[p]) begin
                    mValid[p] = 0;
                end
            end
            mMiss = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
            if (cfgWe && !mLocked && int'(cfgIdx) < NR) begin
                mBase[cfgIdx] = cfgBase; mLen[cfgIdx] = cfgLen;
                mAttr[cfgIdx] = cfgAttr; mEn[cfgIdx] = cfgEn;
            end
            if (cfgLock) mLocked = 1;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rsp_valid[%0d]", p), rspValid[p], mValid[p]);
            chk($sformatf("req_ready[%0d]", p), reqReady[p],
                (!rst && (!mValid[p] || rspReady[p])) ? 1 : 0);
            if (mValid[p]) begin
                chk($sformatf("rsp_id[%0d]", p), rspId[p*IW +: IW], mId[p]);
                chk($sformatf("rsp_attr[%0d]", p), rspAttr[p*3 +: 3], mRAttr[p]);
                chk($sformatf("rsp_hit[%0d]", p), rspHit[p], mHit[p]);
                chk($sformatf("rsp_multi[%0d]", p), rspMulti[p], mMulti[p]);
            end
        end
        chk("miss_cnt", missCnt, mMiss);
        chk("cfg_locked", cfgLocked, mLocked);
    endtask

    task automatic setReq(input int p, input bit v, input logic [63:0] a, input logic [3:0] id);
        reqValid[p] = v;
        reqAddr[p*AW +: AW] = a;
        reqId[p*IW +: IW] = id;
    endtask

    task automatic setCfg(input bit we, input logic [3:0] idx, input logic [63:0] b,
                          input logic [63:0] l, input logic [2:0] at, input bit en);
        cfgWe = we; cfgIdx = idx; cfgBase = b; cfgLen = l; cfgAttr = at; cfgEn = en;
    endtask

    task automatic writeRule(input logic [3:0] idx, input logic [63:0] b,
                             input logic [63:0] l, input logic [2:0] at, input bit en);
        setCfg(1, idx, b, l, at, en);
        cycle();
        cfgWe = 0;
    endtask

    initial begin
        logic [2:0] snapAttr;
        logic [63:0] bases [4];
        rst = 1; cfgLock = 0; reqValid = '0; reqAddr = '0; reqId = '0; rspReady = '0;
        setCfg(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("reset rsp_valid", rspValid, 0);
        chk("reset rsp_attr", rspAttr, 0);
        chk("reset rsp_id", rspId, 0);
        chk("reset hit/multi", {rspHit, rspMulti}, 0);
        chk("reset req_ready", reqReady, 0);
        rst = 0;
        cycle();
        chk("ready after reset", reqReady, 2'b11);

        // Empty table: execute defaults to 1, nothing hits
        rspReady = 2'b11;
        setReq(0, 1, 64'h1234, 4'h9);
        setReq(1, 1, 64'hDEAD_0000, 4'hA);
        cycle();
        chk("empty attr p0", rspAttr[2:0], 3'b010);
        chk("empty attr p1", rspAttr[5:3], 3'b010);
        chk("empty hit", rspHit, 2'b00);
        reqValid = '0;
        cycle();
        chk("empty miss count", missCnt, 2);

        writeRule(0, 64'h8000_0000, 64'h4000_0000, 3'b110, 1);
        writeRule(1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b001, 1);
        writeRule(3, 64'h0, 64'h0, 3'b100, 1);
        writeRule(4, 64'h8000_0000, 64'h1000, 3'b001, 1);

        vecs[0] = '{64'h8000_1000,          4'h3, 3'b110, 1, 0};
        vecs[1] = '{64'hC000_0000,          4'h5, 3'b000, 0, 0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 4'h6, 3'b001, 1, 0};
        vecs[3] = '{64'h0,                  4'h7, 3'b000, 0, 0};
        vecs[4] = '{64'h8000_0800,          4'h1, 3'b111, 1, 1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_EFFF, 4'h2, 3'b000, 0, 0};
        vecs[6] = '{64'hBFFF_FFFF,          4'h4, 3'b110, 1, 0};
        for (int i = 0; i < 7; i++) begin
            setReq(0, 1, vecs[i].addr, vecs[i].id);
            cycle();
            chk($sformatf("vec%0d valid", i), rspValid[0], 1);
            chk($sformatf("vec%0d id", i), rspId[3:0], vecs[i].id);
            chk($sformatf("vec%0d attr", i), rspAttr[2:0], vecs[i].attr);
            chk($sformatf("vec%0d hit", i), rspHit[0], vecs[i].hit);
            chk($sformatf("vec%0d multi", i), rspMulti[0], vecs[i].multi);
            if (i == 1) chk("miss before handshake", missCnt, 2);
            if (i == 2) chk("miss after handshake", missCnt, 3);
        end
        reqValid = '0;
        cycle();
        chk("miss after vectors", missCnt, 5);

        // Port1 stalled for 3 cycles while port0 streams
        rspReady = 2'b01;
        setReq(1, 1, 64'h8000_1000, 4'hB);
        setReq(0, 1, 64'h8000_0010, 4'h0);
        cycle();
        snapAttr = rspAttr[5:3];
        setReq(1, 1, 64'hC000_0000, 4'hC);
        for (int i = 1; i <= 3; i++) begin
            setReq(0, 1, 64'h8000_0010 + 64'(i), 4'(i));
            cycle();
            chk("stall p1 ready", reqReady[1], 0);
            chk("stall p1 id", rspId[7:4], 4'hB);
            chk("stall p1 attr", rspAttr[5:3], snapAttr);
            chk("stream p0 valid", rspValid[0], 1);
            chk("stream p0 id", rspId[3:0], 4'(i));
        end
        rspReady = 2'b11;
        cycle();
        chk("p1 released id", rspId[7:4], 4'hC);
        reqValid = '0;
        cycle();

        // Same-cycle write sees the old table; next accept sees the new one
        setReq(0, 1, 64'h1000_0010, 4'h1);
        setCfg(1, 2, 64'h1000_0000, 64'h100, 3'b100, 1);
        cycle();
        cfgWe = 0;
        chk("hazard old hit", rspHit[0], 0);
        chk("hazard old attr", rspAttr[2:0], 3'b000);
        setReq(0, 1, 64'h1000_0010, 4'h2);
        cycle();
        chk("hazard new hit", rspHit[0], 1);
        chk("hazard new attr", rspAttr[2:0], 3'b100);
        reqValid = '0;

        cfgLock = 1;
        cycle();
        cfgLock = 0;
        chk("locked", cfgLocked, 1);
        writeRule(0, 64'h8000_0000, 64'h4000_0000, 3'b110, 0);
        setReq(0, 1, 64'h8000_1000, 4'h5);
        cycle();
        chk("locked rule0 hit", rspHit[0], 1);
        chk("locked rule0 attr", rspAttr[2:0], 3'b110);
        reqValid = '0;
        cycle();

        // Random traffic against the model, with occasional resets
        rst = 1;
        cycle();
        rst = 0;
        bases[0] = 64'h0;
        bases[1] = 64'h8000_0000;
        bases[2] = 64'hFFFF_FFFF_FFFF_F000;
        bases[3] = 64'h1000_0000;
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] len;
            rst = ($urandom_range(0, 799) == 0);
            case ($urandom_range(0, 3))
                0: len = 64'h0;
                1: len = 64'($urandom_range(1, 511));
                2: len = 64'h1000;
                default: len = {$urandom, $urandom};
            endcase
            setCfg($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                   bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 255)),
                   len, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            cfgLock = (i == 3500);
            for (int p = 0; p < NP; p++) begin
                setReq(p, $urandom_range(0, 2) != 0,
                       bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 1023)) - 64'h100,
                       4'($urandom_range(0, 15)));
                rspReady[p] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pma_region_checker.md
Name: pma_region_checker

Overview:
- Runtime-programmable physical-memory-attribute checker.
- Replaces the static non-idempotent, execute and cacheable region functions with one rule table programmed from CSR/boot logic.
- Serves NrPorts independent lookup channels (e.g. fetch, load/store), each with a one-cycle registered lookup and valid/ready backpressure.
- Reports attributes, hit, and multi-match per lookup.

Parameters:
- NrRules, 16, number of rule entries (1..64).
- NrPorts, 2, number of independent lookup channels (1..4).
- AddrWidth, 64, physical address width.
- IdWidth, 4, request tag width, echoed on the response.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_we_i  in  1  rule write strobe.
- cfg_idx_i  in  $clog2(NrRules)  rule index to write.
- cfg_base_i  in  AddrWidth  region base.
- cfg_len_i  in  AddrWidth  region length in bytes.
- cfg_attr_i  in  3  {cacheable, execute, nonidempotent}.
- cfg_en_i  in  1  rule enable.
- cfg_lock_i  in  1  sets table lock.
- cfg_locked_o  out  1  table locked.
- req_valid_i  in  NrPorts  lookup request valid.
- req_ready_o  out  NrPorts  lookup request ready.
- req_addr_i  in  NrPorts*AddrWidth  lookup address.
- req_id_i  in  NrPorts*IdWidth  request tag.
- rsp_valid_o  out  NrPorts  response valid.
- rsp_ready_i  in  NrPorts  response ready.
- rsp_id_o  out  NrPorts*IdWidth  echoed tag.
- rsp_attr_o  out  NrPorts*3  resolved attributes.
- rsp_hit_o  out  NrPorts  at least one enabled rule matched.
- rsp_multi_o  out  NrPorts  two or more enabled rules matched.
- miss_cnt_o  out  32  saturating count of delivered responses with hit=0, summed over all ports.

Behaviour:
- Reset:
  - All rules get en=0, base=0, len=0, attr=0.
  - cfg_locked_o=0, rsp_valid_o=0, rsp_id_o/attr/hit/multi=0, miss_cnt_o=0.
  - req_ready_o=all-ones one cycle after reset deasserts; it is 0 while rst_i=1.
  - Reset mid-transaction drops any held response.
- Rule writes:
  - Write applies at the clock edge when cfg_we_i=1 and locked=0.
  - cfg_idx_i >= NrRules: write ignored.
  - cfg_lock_i=1 sets locked at the clock edge; only reset clears it.
  - If cfg_we_i and cfg_lock_i are asserted in the same cycle while unlocked, the write applies and the lock sets.
- Match for rule k:
  - Requires en[k]=1 and addr >= base[k].
  - Requires {1'b0,addr} < base[k]+len[k], summed at AddrWidth+1 bits so no overflow.
  - len[k]=0 never matches.
- Attribute resolution:
  - nonidempotent = OR of attr[0] over matching rules.
  - cacheable = OR of attr[2] over matching rules.
  - execute = OR of attr[1] over matching rules, except execute=1 when no enabled rule in the table has attr[1]=1.
  - hit = any match; multi = popcount(match) >= 2.
- Per-port pipeline:
  - Single output register per port. req_ready_o[p] = !rsp_valid_o[p] | rsp_ready_i[p].
  - Accept when valid&ready: the response register loads next edge, so latency is 1 cycle.
  - Response outputs hold stable while rsp_valid_o=1 and rsp_ready_i=0.
  - Back-to-back accepts sustain 1 lookup/cycle/port.
  - Ports are fully independent; no cross-port stalls.
- Write/lookup hazard: a lookup accepted in the same cycle as a rule write sees the OLD table; lookups accepted in later cycles see the new table.
- miss_cnt_o:
  - Increments by the number of ports completing a response handshake (rsp_valid&rsp_ready) with hit=0 in that cycle.
  - Saturates at 32'hFFFF_FFFF.

Test Plan:
- Reset, rule0 {base=0x8000_0000, len=0x4000_0000, attr=cacheable|execute, en}, port0 lookup 0x8000_1000 id=3 -> next cycle rsp_valid=1, id=3, attr=3'b110, hit=1, multi=0.
- Same table, lookup 0xC000_0000 (one past end) -> hit=0, attr=3'b000, execute=0 (an exec rule exists); miss_cnt_o 0→1 after handshake.
- Empty table, lookup any address -> attr=3'b010 (execute default), hit=0.
- Rule with base=0xFFFF_FFFF_FFFF_F000, len=0x2000, lookup 0xFFFF_FFFF_FFFF_FFF8 -> hit=1 (no wrap false-negative); len=0 rule never matches.
- Port1 rsp_ready_i=0 for 3 cycles with port0 streaming -> port1 req_ready_o=0, outputs stable; port0 delivers 1/cycle.
- Lock set, then a write to rule0 with en=0 -> ignored, lookups still hit. Write to rule2 in the same cycle as a port0 accept -> that response uses the old rule2, the next accept uses the new one.
